// File: rtl/program_memory_bus_pkg.sv
// Shared types, sizes and the address region decode for program_memory_bus.
package mem_bus_pkg;

  localparam int               BUS_ADDR_W       = 13;
  localparam int               BUS_DATA_W       = 8;
  localparam logic [12:0]      RAM_BASE_DEFAULT = 13'h1800;
  localparam int               ROM_DEPTH        = int'(RAM_BASE_DEFAULT);
  localparam int               RAM_DEPTH        = (1 << BUS_ADDR_W) - ROM_DEPTH;

  typedef enum logic {ST_LOAD, ST_RUN} state_t;
  typedef enum logic {IS_ROM, IS_RAM} region_t;

  // ROM sits below the RAM base, RAM from the base to the top of the map.
  function automatic region_t decode_region(input int unsigned a, input int unsigned base);
    return (a >= base) ? IS_RAM : IS_ROM;
  endfunction

endpackage

// File: rtl/program_memory_bus_if.sv
// CPU strobes/address, loader stream and status for program_memory_bus.
// Loader handshake: a byte moves on a rising clk edge where ld_valid and
// ld_ready are both 1; ld_data and ld_last are only meaningful with ld_valid.
// The bidirectional data bus stays a plain port on the memory module.
interface program_memory_bus_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              cpu_rst_n;
  logic              loaded;
  logic              bus_err;
  // Debug view: FSM state and the data bus output enable.
  mem_bus_pkg::state_t state;
  logic              data_oe;

  modport slave (
    input  rd, wr, addr, ld_valid, ld_data, ld_last,
    output ld_ready, cpu_rst_n, loaded, bus_err, state, data_oe
  );

  modport master (
    output rd, wr, addr, ld_valid, ld_data, ld_last,
    input  ld_ready, cpu_rst_n, loaded, bus_err, state, data_oe
  );
endinterface

// File: rtl/program_memory_bus_byte_ram.sv
// Single-port byte memory: synchronous write, registered read on enable.
module byte_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read share the single address port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/program_memory_bus.sv
// Loads a program image into ROM while holding the CPU in reset, then serves
// CPU reads (ROM/RAM, one-cycle latency) and writes (RAM only).
module program_memory_bus
  import mem_bus_pkg::*;
#(
  parameter int               ADDR_W   = BUS_ADDR_W,
  parameter int               DATA_W   = BUS_DATA_W,
  parameter logic [ADDR_W-1:0] RAM_BASE = ADDR_W'(RAM_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [DATA_W-1:0] data,
  program_memory_bus_if.slave bus
);

  localparam int ROM_WORDS = int'(RAM_BASE);
  localparam int RAM_WORDS = (1 << ADDR_W) - ROM_WORDS;
  localparam int ROM_AW    = $clog2(ROM_WORDS);
  localparam int RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ROM = RAM_BASE - ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] load_ptr;
  logic              rd_q, wr_q, ovl_q, ram_sel_q;
  logic              ld_ready, cpu_rst_n, loaded, bus_err;
  logic              ld_fire, go_run, in_run, rd_only, run_rd, wr_rise;
  logic              is_ram, rom_we, ram_we, err_now, data_oe;
  logic [ROM_AW-1:0] rom_addr;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] rom_rdata, ram_rdata, rdata;

  assign in_run   = (state == ST_RUN);
  assign ld_fire  = (state == ST_LOAD) & ld_ready & bus.ld_valid;
  // The last ROM slot ends the load even without ld_last, so no wrap.
  assign go_run   = ld_fire & (bus.ld_last | (load_ptr == LAST_ROM));
  assign rd_only  = bus.rd & ~bus.wr;
  assign run_rd   = in_run & rd_only;
  assign wr_rise  = in_run & bus.wr & ~wr_q;
  assign is_ram   = (decode_region(32'(bus.addr), 32'(RAM_BASE)) == IS_RAM);
  assign rom_we   = rst_n & ld_fire;
  assign ram_we   = rst_n & wr_rise & is_ram;
  // Illegal: a write edge into ROM, or the first cycle of rd/wr overlap.
  assign err_now  = in_run & ((wr_rise & ~is_ram) | (bus.rd & bus.wr & ~ovl_q));
  assign rom_addr = ROM_AW'(in_run ? bus.addr : load_ptr);
  assign ram_addr = RAM_AW'(bus.addr - RAM_BASE);

  byte_ram #(.DEPTH(ROM_WORDS), .DATA_W(DATA_W), .AW(ROM_AW)) u_rom (
    .clk   (clk),
    .en    (run_rd),
    .we    (rom_we),
    .addr  (rom_addr),
    .wdata (bus.ld_data),
    .rdata (rom_rdata)
  );

  byte_ram #(.DEPTH(RAM_WORDS), .DATA_W(DATA_W), .AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (run_rd),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data),
    .rdata (ram_rdata)
  );

  // Load/run FSM with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      load_ptr  <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ovl_q     <= 1'b0;
      ram_sel_q <= 1'b0;
      bus_err   <= 1'b0;
      ld_ready  <= 1'b0;
      cpu_rst_n <= 1'b0;
      loaded    <= 1'b0;
    end else begin
      wr_q <= bus.wr;
      case (state)
        ST_LOAD: begin
          rd_q    <= 1'b0;
          ovl_q   <= 1'b0;
          bus_err <= 1'b0;
          if (ld_fire) load_ptr <= load_ptr + ADDR_W'(1);
          if (go_run) begin
            state     <= ST_RUN;
            ld_ready  <= 1'b0;
            cpu_rst_n <= 1'b1;
            loaded    <= 1'b1;
          end else begin
            ld_ready  <= 1'b1;
            cpu_rst_n <= 1'b0;
            loaded    <= 1'b0;
          end
        end
        ST_RUN: begin
          rd_q      <= rd_only;
          ovl_q     <= bus.rd & bus.wr;
          bus_err   <= err_now;
          if (run_rd) ram_sel_q <= is_ram;
          ld_ready  <= 1'b0;
          cpu_rst_n <= 1'b1;
          loaded    <= 1'b1;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Drive only while the read that filled rdata is still being held.
  assign rdata   = ram_sel_q ? ram_rdata : rom_rdata;
  assign data_oe = rd_q & rd_only;
  assign data    = data_oe ? rdata : {DATA_W{1'bz}};

  assign bus.ld_ready  = ld_ready;
  assign bus.cpu_rst_n = cpu_rst_n;
  assign bus.loaded    = loaded;
  assign bus.bus_err   = bus_err;
  assign bus.state     = state;
  assign bus.data_oe   = data_oe;

endmodule

// File: tb/tb_program_memory_bus.sv
// Directed bench for program_memory_bus: load, RAM/ROM access, overlap,
// streaming reads, mid-run reset and a full-size ROM load.
module tb_program_memory_bus;
  import mem_bus_pkg::*;

  logic       clk;
  logic       rst_n;
  wire  [7:0] data;
  logic       tb_oe;
  logic [7:0] tb_dout;
  int         n_tests;
  int         n_fail;

  program_memory_bus_if bus ();

  program_memory_bus dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .bus   (bus)
  );

  assign data = tb_oe ? tb_dout : 8'hzz;

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic bus_write(input logic [12:0] a, input logic [7:0] d);
    bus.addr = a;
    tb_dout  = d;
    tb_oe    = 1'b1;
    bus.wr   = 1'b1;
    tick();
    bus.wr   = 1'b0;
    tb_oe    = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [12:0] a, input logic [7:0] exp);
    bus.addr = a;
    bus.rd   = 1'b1;
    tick();
    check({tag, "_oe"}, 32'(bus.data_oe), 32'd1);
    check(tag, 32'(data), 32'(exp));
    bus.rd = 1'b0;
    #1;
    check({tag, "_release"}, 32'(bus.data_oe), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    tb_oe = 1'b0;
    tb_dout = 8'h00;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.addr = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data = 8'h00;
    bus.ld_last = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    check("rst_loaded", 32'(bus.loaded), 32'd0);
    check("rst_bus_err", 32'(bus.bus_err), 32'd0);
    check("rst_oe", 32'(bus.data_oe), 32'd0);
    check("rst_state", 32'(bus.state), 32'(ST_LOAD));
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(bus.ld_ready), 32'd1);

    // Load three bytes; a CPU read during load must not drive the bus.
    bus.rd = 1'b1;
    load_byte(8'h11, 1'b0);
    check("load_rd_ignored", 32'(bus.data_oe), 32'd0);
    bus.rd = 1'b0;
    load_byte(8'h22, 1'b0);
    check("load_mid_cpu_rst", 32'(bus.cpu_rst_n), 32'd0);
    load_byte(8'h33, 1'b1);
    check("load_done_ready", 32'(bus.ld_ready), 32'd0);
    check("load_done_cpu_rst", 32'(bus.cpu_rst_n), 32'd1);
    check("load_done_loaded", 32'(bus.loaded), 32'd1);
    check("load_done_state", 32'(bus.state), 32'(ST_RUN));
    bus_read("rom0", 13'h0000, 8'h11);
    bus_read("rom1", 13'h0001, 8'h22);
    bus_read("rom2", 13'h0002, 8'h33);

    // RAM write then immediate read-back.
    bus_write(13'h1800, 8'hA5);
    check("ram_wr_err", 32'(bus.bus_err), 32'd0);
    bus_read("ram1800", 13'h1800, 8'hA5);

    // ROM write protection.
    bus_write(13'h0001, 8'hFF);
    check("rom_wr_err", 32'(bus.bus_err), 32'd1);
    tick();
    check("rom_wr_err_end", 32'(bus.bus_err), 32'd0);
    bus_read("rom1_kept", 13'h0001, 8'h22);

    // Write held three cycles writes once (later data must not land).
    bus.addr = 13'h1801;
    tb_dout  = 8'h5A;
    tb_oe    = 1'b1;
    bus.wr   = 1'b1;
    tick();
    tb_dout = 8'h77;
    tick();
    tick();
    check("hold_err", 32'(bus.bus_err), 32'd0);
    bus.wr = 1'b0;
    tb_oe  = 1'b0;
    tick();
    bus_read("ram1801_once", 13'h1801, 8'h5A);

    // Overlap: write edge alone, then rd joins; single err pulse, no drive.
    bus.addr = 13'h1802;
    tb_dout  = 8'h3C;
    tb_oe    = 1'b1;
    bus.wr   = 1'b1;
    tick();
    check("ovl_pre_err", 32'(bus.bus_err), 32'd0);
    bus.rd = 1'b1;
    tick();
    check("ovl_err", 32'(bus.bus_err), 32'd1);
    check("ovl_oe", 32'(bus.data_oe), 32'd0);
    tick();
    check("ovl_err_end", 32'(bus.bus_err), 32'd0);
    check("ovl_oe2", 32'(bus.data_oe), 32'd0);
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    tb_oe  = 1'b0;
    tick();

    // Streaming reads with rd held high.
    bus.rd   = 1'b1;
    bus.addr = 13'h1800;
    tick();
    check("stream0", 32'(data), 32'h0A5);
    bus.addr = 13'h1801;
    tick();
    check("stream1", 32'(data), 32'h05A);
    bus.addr = 13'h1802;
    tick();
    check("stream2", 32'(data), 32'h03C);
    bus.rd = 1'b0;
    tick();

    // Mid-run reset keeps memory contents.
    rst_n = 1'b0;
    tick();
    check("mrst_cpu_rst", 32'(bus.cpu_rst_n), 32'd0);
    check("mrst_state", 32'(bus.state), 32'(ST_LOAD));
    check("mrst_oe", 32'(bus.data_oe), 32'd0);
    check("mrst_loaded", 32'(bus.loaded), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mrst_ready", 32'(bus.ld_ready), 32'd1);
    load_byte(8'h44, 1'b1);
    check("reload_state", 32'(bus.state), 32'(ST_RUN));
    bus_read("reload_rom0", 13'h0000, 8'h44);
    bus_read("reload_ram", 13'h1800, 8'hA5);
    bus_read("reload_rom1", 13'h0001, 8'h22);

    // Full load without ld_last: transition on the final ROM byte.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6144; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'(i) ^ 8'h5A;
      bus.ld_last  = 1'b0;
      tick();
      if (i == 6142) begin
        check("full_pre_ready", 32'(bus.ld_ready), 32'd1);
        check("full_pre_state", 32'(bus.state), 32'(ST_LOAD));
      end
    end
    check("full_ready", 32'(bus.ld_ready), 32'd0);
    check("full_state", 32'(bus.state), 32'(ST_RUN));
    check("full_cpu_rst", 32'(bus.cpu_rst_n), 32'd1);
    bus.ld_data = 8'hEE;
    tick();
    check("full_extra_ready", 32'(bus.ld_ready), 32'd0);
    check("full_extra_loaded", 32'(bus.loaded), 32'd1);
    bus.ld_valid = 1'b0;
    bus_read("full_rom0", 13'h0000, 8'h5A);
    bus_read("full_rom1", 13'h0001, 8'h5B);
    bus_read("full_rom_last", 13'h17FF, 8'hA5);
    bus_read("full_ram", 13'h1800, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
